// File: rtl/keypad_emulator.sv
// Keypad-side responder for the 4x4 matrix scan: queues key indices and answers row drive with column returns.
// Define KEY_BOUNCE_EN to add contact chatter at the start of each press and release.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 50,
  parameter int unsigned GAP_CYCLES    = 50,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned BOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fila,
  output logic [3:0] col,
  input  logic [3:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       busy,
  output logic       pressed,
  output logic       key_done
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  // Counter is wide enough to also hold the bounce length for the elapsed-time compare.
  localparam int unsigned CW      = $clog2(CNT_MAX + BOUNCE_CYCLES) + 1;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_V = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    cur_key, cur_n;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ, occ_n;
  logic          do_push, do_pop;
  logic          pressed_n, done_n, busy_n, ready_n;
  logic [3:0]    col_n;
`ifdef KEY_BOUNCE_EN
  localparam logic [CW-1:0] BOUNCE_V = CW'(BOUNCE_CYCLES);
  logic [CW-1:0] elapsed;
`endif

  always_comb begin
    do_push = key_valid && key_ready;
    do_pop  = (state == IDLE) && (occ != '0);

    occ_n = occ;
    if (do_push && !do_pop)
      occ_n = occ + (AW + 1)'(1);
    else if (!do_push && do_pop)
      occ_n = occ - (AW + 1)'(1);

    state_n = state;
    cnt_n   = cnt;
    cur_n   = cur_key;
    case (state)
      IDLE: if (do_pop) begin
        state_n = PRESS;
        cnt_n   = HOLD_LD;
        cur_n   = mem[rd_ptr];
      end
      PRESS: if (cnt == '0) begin
        state_n = GAP;
        cnt_n   = GAP_LD;
      end else begin
        cnt_n = cnt - CW'(1);
      end
      GAP: if (cnt == '0)
        state_n = IDLE;
      else
        cnt_n = cnt - CW'(1);
      default: state_n = IDLE;
    endcase

    done_n  = (state_n == PRESS) && (cnt_n == '0);
    busy_n  = (state_n != IDLE) || (occ_n != '0);
    ready_n = (occ_n != DEPTH_V);

`ifdef KEY_BOUNCE_EN
    // Chatter phase is measured from the reload value, so even elapsed cycles read as contact.
    elapsed = ((state_n == PRESS) ? HOLD_LD : GAP_LD) - cnt_n;
    case (state_n)
      PRESS:   pressed_n = (elapsed < BOUNCE_V) ? ~elapsed[0] : 1'b1;
      GAP:     pressed_n = (elapsed < BOUNCE_V) ? ~elapsed[0] : 1'b0;
      default: pressed_n = 1'b0;
    endcase
`else
    pressed_n = (state_n == PRESS);
`endif

    // Column return is driven from the registered contact state, one cycle behind pressed.
    col_n = (pressed && !fila[cur_key[3:2]]) ? ~(4'b0001 << cur_key[1:0]) : 4'hF;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= key_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_key   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      col       <= '1;
      pressed   <= 1'b0;
      key_done  <= 1'b0;
      busy      <= 1'b0;
      key_ready <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cur_key   <= cur_n;
      occ       <= occ_n;
      col       <= col_n;
      pressed   <= pressed_n;
      key_done  <= done_n;
      busy      <= busy_n;
      key_ready <= ready_n;
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
    end
  end

endmodule
